// File: rtl/memory_stage.sv
// Memory stage and M/W pipeline register: lw/sw over a req/ack data port,
// stalling upstream until the access completes or times out.
module memory_stage #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_xm,
  input  logic [31:0]           ir_xm,
  input  logic [31:0]           output_xm,
  input  logic [31:0]           b_xm,
  input  logic                  exception_xm,
  output logic                  stall_m,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  valid_mw,
  output logic [31:0]           ir_mw,
  output logic [31:0]           output_mw,
  output logic [31:0]           data_mw,
  output logic                  exception_mw,
  output logic                  mem_fault
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [31:0]           hold_ir_q, hold_ir_d;
  logic [31:0]           hold_out_q, hold_out_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic [31:0]           ir_q, ir_d;
  logic [31:0]           out_q, out_d;
  logic [31:0]           data_q, data_d;
  logic                  exc_q, exc_d;
  logic                  fault_q, fault_d;

  logic is_sw, is_lw, memop, hold_lw, last;

  assign is_sw   = ir_xm[31:27] == OP_SW;
  assign is_lw   = ir_xm[31:27] == OP_LW;
  assign memop   = valid_xm & ~exception_xm & (is_sw | is_lw);
  assign hold_lw = hold_ir_q[31:27] == OP_LW;
  assign last    = cnt_q == CNT_LAST;

  // Ack takes priority over the timeout on the final WAIT cycle
  assign stall_m = (state_q == S_IDLE) ? memop
                                       : ~(dmem_ack | last);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_ir_d  = hold_ir_q;
    hold_out_d = hold_out_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = 1'b0;
    ir_d       = 32'h0;
    out_d      = 32'h0;
    data_d     = 32'h0;
    exc_d      = 1'b0;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          hold_ir_d  = ir_xm;
          hold_out_d = output_xm;
          addr_d     = output_xm[ADDR_WIDTH-1:0];
          wdata_d    = b_xm;
          we_d       = is_sw;
          req_d      = 1'b1;
          cnt_d      = 8'h0;
          state_d    = S_WAIT;
        end else begin
          valid_d = valid_xm;
          ir_d    = valid_xm ? ir_xm : 32'h0;
          out_d   = output_xm;
          exc_d   = valid_xm & exception_xm;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          valid_d = 1'b1;
          ir_d    = hold_ir_q;
          out_d   = hold_out_q;
          data_d  = hold_lw ? dmem_rdata : 32'h0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = 8'h0;
          state_d = S_IDLE;
        end else if (last) begin
          valid_d = 1'b1;
          ir_d    = hold_ir_q;
          out_d   = hold_out_q;
          exc_d   = 1'b1;
          fault_d = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = 8'h0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'h0;
      hold_ir_q  <= 32'h0;
      hold_out_q <= 32'h0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      valid_q    <= 1'b0;
      ir_q       <= 32'h0;
      out_q      <= 32'h0;
      data_q     <= 32'h0;
      exc_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_ir_q  <= hold_ir_d;
      hold_out_q <= hold_out_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      ir_q       <= ir_d;
      out_q      <= out_d;
      data_q     <= data_d;
      exc_q      <= exc_d;
      fault_q    <= fault_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign valid_mw     = valid_q;
  assign ir_mw        = ir_q;
  assign output_mw    = out_q;
  assign data_mw      = data_q;
  assign exception_mw = exc_q;
  assign mem_fault    = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: random lw/sw/ALU traffic against a
// behavioural memory model with a randomly slow data-memory responder.
module tb_memory_stage;

  localparam int AW = 12;
  localparam int TO = 16;
  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;

  logic          clock = 1'b0;
  logic          reset;
  logic          valid_xm;
  logic [31:0]   ir_xm, output_xm, b_xm;
  logic          exception_xm;
  logic          stall_m;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic          dmem_ack, ack_r, ack_spur;
  logic          valid_mw;
  logic [31:0]   ir_mw, output_mw, data_mw;
  logic          exception_mw, mem_fault;

  assign dmem_ack = ack_r | ack_spur;

  always #5 clock = ~clock;

  memory_stage #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .valid_xm(valid_xm), .ir_xm(ir_xm), .output_xm(output_xm),
    .b_xm(b_xm), .exception_xm(exception_xm), .stall_m(stall_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .valid_mw(valid_mw), .ir_mw(ir_mw), .output_mw(output_mw),
    .data_mw(data_mw), .exception_mw(exception_mw), .mem_fault(mem_fault)
  );

  typedef struct {
    logic [31:0] ir, out, data;
    logic        exc, fault;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   wdata;
    int            lat;
    int            req_cycles;
  } req_t;

  exp_t        expq[$];
  req_t        reqq[$];
  logic [31:0] shadow[int];
  logic [31:0] rmem[int];
  logic        model_fault;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one instruction into X/M and hold it while stall_m is high
  task automatic issue(input logic v, input logic [31:0] ir,
                       input logic [31:0] out, input logic [31:0] b,
                       input logic exc, input int lat, input logic spur);
    logic [4:0] op;
    logic       mem, sw, tmo, s;
    int         a, n, stalls, exp_stall;
    exp_t       e;
    req_t       r;
    op  = ir[31:27];
    mem = v && !exc && (op == OP_SW || op == OP_LW);
    sw  = op == OP_SW;
    tmo = mem && lat >= TO;
    a   = int'(out[AW-1:0]);
    if (mem) begin
      r.addr = out[AW-1:0];
      r.we = sw;
      r.wdata = b;
      r.lat = lat;
      r.req_cycles = TO;
      reqq.push_back(r);
    end
    if (tmo) model_fault = 1'b1;
    if (v) begin
      e.ir = ir;
      e.out = out;
      e.exc = exc || tmo;
      e.fault = model_fault;
      e.data = 32'h0;
      if (mem && !sw && !tmo)
        e.data = shadow.exists(a) ? shadow[a] : 32'h0;
      expq.push_back(e);
    end
    if (mem && sw && !tmo) shadow[a] = b;
    exp_stall = !mem ? 0 : (tmo ? TO : lat + 1);
    valid_xm = v;
    ir_xm = ir;
    output_xm = out;
    b_xm = b;
    exception_xm = exc;
    ack_spur = spur && !mem;
    n = 0;
    stalls = 0;
    do begin
      @(negedge clock);
      s = stall_m;
      if (s) stalls++;
      n++;
      @(posedge clock);
      #1;
      ack_spur = 1'b0;
    end while (s && n < 400);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    valid_xm = 1'b0;
  endtask

  // Data-memory responder with per-request latency from the request queue
  initial begin : responder
    req_t r;
    int   cnt, a;
    ack_r = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && dmem_req) begin
        if (reqq.size() == 0) begin
          chk("unexpected_req", 32'(dmem_req), 32'h0);
          cnt = 0;
          while (dmem_req && cnt < 400) begin
            @(posedge clock);
            #1;
            cnt++;
          end
        end else begin
          r = reqq.pop_front();
          a = int'(r.addr);
          chk("dmem_addr", 32'(dmem_addr), 32'(r.addr));
          chk("dmem_we", 32'(dmem_we), 32'(r.we));
          if (r.we) chk("dmem_wdata", dmem_wdata, r.wdata);
          if (r.lat < TO) begin
            repeat (r.lat) begin
              @(posedge clock);
              #1;
            end
            ack_r = 1'b1;
            if (r.we) begin
              dmem_rdata = $urandom;
              rmem[a] = dmem_wdata;
            end else begin
              dmem_rdata = rmem.exists(a) ? rmem[a] : 32'h0;
            end
            @(posedge clock);
            #1;
            ack_r = 1'b0;
            dmem_rdata = $urandom;
            chk("req_drop", 32'(dmem_req), 32'h0);
          end else begin
            cnt = 0;
            while (dmem_req && cnt < 400) begin
              @(posedge clock);
              #1;
              cnt++;
            end
            chk("req_cycles", 32'(cnt), 32'(r.req_cycles));
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (valid_mw) begin
        if (expq.size() == 0) begin
          chk("unexpected_retire", 32'(valid_mw), 32'h0);
        end else begin
          e = expq.pop_front();
          chk("ir_mw", ir_mw, e.ir);
          chk("output_mw", output_mw, e.out);
          chk("data_mw", data_mw, e.data);
          chk("exception_mw", 32'(exception_mw), 32'(e.exc));
          chk("mem_fault", 32'(mem_fault), 32'(e.fault));
        end
      end else begin
        chk("bubble_ir", ir_mw, 32'h0);
      end
    end
  end

  logic [31:0] rir, rout;
  logic        rv, rexc, rspur;
  int          rsel, rlat, rp, drain;

  initial begin
    reset = 1'b1;
    valid_xm = 1'b0;
    ir_xm = 32'h0;
    output_xm = 32'h0;
    b_xm = 32'h0;
    exception_xm = 1'b0;
    ack_spur = 1'b0;
    model_fault = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_addr", 32'(dmem_addr), 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_valid", 32'(valid_mw), 32'h0);
    chk("rst_data", data_mw, 32'h0);
    chk("rst_exc", 32'(exception_mw), 32'h0);
    chk("rst_fault", 32'(mem_fault), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    issue(1'b1, 32'h0, 32'd7, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b1, 32'h0, 32'd7, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b1, {OP_SW, 27'h0}, 32'h123, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    issue(1'b1, {OP_LW, 27'h0}, 32'h123, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b1, {OP_SW, 27'h5}, 32'h010, 32'h55, 1'b0, 3, 1'b0);
    issue(1'b1, {OP_LW, 27'h9}, 32'h123, 32'h0, 1'b1, 0, 1'b1);
    issue(1'b1, 32'h0000_0042, 32'd99, 32'h0, 1'b0, 0, 1'b1);
    issue(1'b1, {OP_LW, 27'h1}, 32'h010, 32'h0, 1'b0, TO - 1, 1'b0);
    issue(1'b1, {OP_LW, 27'h2}, 32'h010, 32'h0, 1'b0, TO, 1'b0);
    issue(1'b1, 32'h0, 32'd3, 32'h0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      rsel  = $urandom_range(0, 99);
      rv    = $urandom_range(0, 99) < 88;
      rexc  = $urandom_range(0, 9) == 0;
      rspur = $urandom_range(0, 4) == 0;
      rir   = $urandom;
      if (rsel < 30) rir[31:27] = OP_LW;
      else if (rsel < 60) rir[31:27] = OP_SW;
      else if (rir[31:27] == OP_LW || rir[31:27] == OP_SW)
        rir[31:27] = 5'h0;
      rout = $urandom;
      rout[AW-1:0] = 12'($urandom_range(0, 7));
      rp = $urandom_range(0, 19);
      rlat = (rp == 0) ? TO : (rp == 1) ? TO - 1 : $urandom_range(0, 4);
      issue(rv, rir, rout, $urandom, rexc, rlat, rspur);
    end

    // Reset in the second WAIT cycle abandons the access
    begin
      req_t r;
      r.addr = 12'h040;
      r.we = 1'b0;
      r.wdata = 32'h0;
      r.lat = 1000;
      r.req_cycles = 2;
      reqq.push_back(r);
    end
    valid_xm = 1'b1;
    ir_xm = {OP_LW, 27'h0};
    output_xm = 32'h040;
    exception_xm = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    valid_xm = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_fault = 1'b0;
    @(negedge clock);
    chk("abort_req", 32'(dmem_req), 32'h0);
    chk("abort_valid", 32'(valid_mw), 32'h0);
    chk("abort_fault", 32'(mem_fault), 32'h0);
    @(posedge clock);
    #1;
    issue(1'b1, 32'h0, 32'd11, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b0, 32'h0, 32'd0, 32'h0, 1'b0, 0, 1'b0);

    drain = 0;
    while ((expq.size() != 0 || reqq.size() != 0) && drain < 50) begin
      @(posedge clock);
      drain++;
    end
    chk("drain_exp", 32'(expq.size()), 32'h0);
    chk("drain_req", 32'(reqq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
